accel_uart_packetizer: RTL and testbench

Sequences one accelerometer sample (X, Y, Z, 16 bits each) into an 8-byte framed packet and feeds it, one byte at a time, into the UART transmitter through its `Tx_EN` / `Tx_DATA` / `Tx_BUSY` interface. It sits between the sensor read-out logic and the transmitter. It owns the transmitter's enable and data inputs, snapshots the sample, generates the header and checksum, and flags overruns and a stalled transmitter.

---
 rtl/accel_uart_packetizer.sv | 146 ++++++++++++++
 tb/tb_accel_uart_packetizer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_uart_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : accel_uart_packetizer
// Description : Frames one accelerometer sample (X, Y, Z, 16 bits each) into
//               an 8-byte packet {HEADER, XH, XL, YH, YL, ZH, ZL, CHK} and
//               hands it byte by byte to a UART transmitter through its
//               Tx_EN / Tx_DATA / Tx_BUSY handshake. CHK is the XOR of
//               bytes 0..6.
// Ports       : clk, reset (async, active-low)
//               sample_valid/sample_ready, x_data/y_data/z_data : sample in
//               tx_busy (in), tx_en/tx_data (out)     : transmitter side
//               pkt_done (pulse), overrun/timeout_err (sticky), clear_flags
// Revision    : 1.0 - initial release
// ============================================================================
module accel_uart_packetizer #(
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [15:0] x_data,
  input  logic [15:0] y_data,
  input  logic [15:0] z_data,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        pkt_done,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        clear_flags
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // The REQ counter starts at 0 on entry, so the last allowed REQ cycle is
  // the one where the counter holds BUSY_TIMEOUT-1.
  localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t      state;
  logic [47:0] snap;
  logic [2:0]  idx;
  logic [7:0]  chk;
  logic [7:0]  tcnt;
  logic [7:0]  cur_byte;
  logic        timeout_hit;

  assign sample_ready = (state == S_IDLE);

  assign timeout_hit = (state == S_REQ) && !tx_busy && (tcnt == TIMEOUT_LAST);

  // Byte 7 is the running checksum; by the time idx reaches 7 it already
  // holds the XOR of bytes 0..6.
  always_comb begin
    cur_byte = chk;
    case (idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = snap[47:40];
      3'd2:    cur_byte = snap[39:32];
      3'd3:    cur_byte = snap[31:24];
      3'd4:    cur_byte = snap[23:16];
      3'd5:    cur_byte = snap[15:8];
      3'd6:    cur_byte = snap[7:0];
      default: cur_byte = chk;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      snap        <= '0;
      idx         <= '0;
      chk         <= '0;
      tcnt        <= '0;
      tx_en       <= 1'b0;
      tx_data     <= 8'h00;
      pkt_done    <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      // Sticky flags: a new event in the same cycle as a clear wins.
      overrun     <= (overrun & ~clear_flags) | (sample_valid & ~sample_ready);
      timeout_err <= (timeout_err & ~clear_flags) | timeout_hit;

      case (state)
        S_IDLE: begin
          if (sample_valid) begin
            snap  <= {x_data, y_data, z_data};
            idx   <= 3'd0;
            chk   <= 8'h00;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          tx_data <= cur_byte;
          if (idx != 3'd7) begin
            chk <= chk ^ cur_byte;
          end
          tcnt  <= 8'd0;
          tx_en <= 1'b1;
          state <= S_REQ;
        end
        S_REQ: begin
          if (tx_busy) begin
            // Drop enable once the frame has started so the transmitter
            // winds down to off instead of restarting on stale data.
            tx_en <= 1'b0;
            state <= S_WAIT;
          end else if (timeout_hit) begin
            tx_en <= 1'b0;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (!tx_busy) begin
            if (idx == 3'd7) begin
              pkt_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              idx   <= idx + 3'd1;
              state <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accel_uart_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_uart_packetizer
// Description : Self-checking bench for accel_uart_packetizer. A small UART
//               transmitter model (off -> idle -> transfer) answers the
//               Tx_EN handshake and records every byte it sends. Packets
//               come from a table of samples with hand-computed byte streams;
//               timeout, overrun/clear and mid-packet reset are directed
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_uart_packetizer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic        clear_flags = 1'b0;
  logic [15:0] x_data = '0;
  logic [15:0] y_data = '0;
  logic [15:0] z_data = '0;
  logic        tx_busy = 1'b0;
  logic        sample_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        pkt_done;
  logic        overrun;
  logic        timeout_err;

  always #5 clk = ~clk;

  accel_uart_packetizer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .x_data       (x_data),
    .y_data       (y_data),
    .z_data       (z_data),
    .tx_busy      (tx_busy),
    .tx_en        (tx_en),
    .tx_data      (tx_data),
    .pkt_done     (pkt_done),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .clear_flags  (clear_flags)
  );

  // ---------------- transmitter model ----------------
  localparam int FRAME = 6;
  localparam logic [1:0] M_OFF = 2'd0, M_IDLE = 2'd1, M_XFER = 2'd2;
  logic [1:0] m_mode = M_OFF;
  int         m_cnt = 0;
  logic       stall = 1'b0;
  logic [7:0] cap[$];

  always @(posedge clk) begin
    if (stall) begin
      m_mode  <= M_OFF;
      tx_busy <= 1'b0;
    end else begin
      case (m_mode)
        M_OFF:  if (tx_en) m_mode <= M_IDLE;
        M_IDLE: begin
          if (tx_en) begin
            m_mode  <= M_XFER;
            tx_busy <= 1'b1;
            m_cnt   <= FRAME;
            cap.push_back(tx_data);
          end else begin
            m_mode <= M_OFF;
          end
        end
        M_XFER: begin
          if (m_cnt == 1) begin
            tx_busy <= 1'b0;
            m_mode  <= M_IDLE;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
        default: m_mode <= M_OFF;
      endcase
    end
  end

  // ---------------- monitors ----------------
  int   rise_cnt = 0;
  int   done_cnt = 0;
  logic en_q = 1'b0;
  always @(negedge clk) begin
    if (tx_en && !en_q) rise_cnt++;
    en_q = tx_en;
    if (pkt_done) done_cnt++;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [4];

  // Offers one sample, waits for pkt_done and compares the transmitted bytes.
  // With poke set, a second sample is offered while byte 3 is on the wire.
  task automatic run_packet(input vec_t v, input string name, input bit poke);
    int r0, d0;
    bit done, poked;
    logic [7:0] b;
    r0 = rise_cnt;
    d0 = done_cnt;
    cap.delete();
    @(negedge clk);
    check({name, " ready"}, 64'(sample_ready), 64'd1);
    x_data = v.x; y_data = v.y; z_data = v.z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    x_data = ~v.x; y_data = ~v.y; z_data = ~v.z;
    done = 1'b0;
    poked = 1'b0;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      @(negedge clk);
      if (sample_valid) sample_valid = 1'b0;
      if (pkt_done) done = 1'b1;
      else if (poke && !poked && cap.size() == 4) begin
        x_data = 16'h5555; y_data = 16'h6666; z_data = 16'h7777;
        sample_valid = 1'b1;
        poked = 1'b1;
      end
    end
    check({name, " pkt_done seen"}, 64'(done), 64'd1);
    #1;
    check({name, " byte count"}, 64'(cap.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      b = (i < cap.size()) ? cap[i] : 8'hxx;
      check($sformatf("%s byte%0d", name, i), 64'(b), 64'(v.exp[63-8*i -: 8]));
    end
    check({name, " tx_en rises"}, 64'(rise_cnt - r0), 64'd8);
    check({name, " pkt_done pulses"}, 64'(done_cnt - d0), 64'd1);
    check({name, " overrun"}, 64'(overrun), poke ? 64'd1 : 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, d0;
    bit seen;

    vecs[0] = '{16'h1234, 16'hABCD, 16'h0F0F, 64'hA5_12_34_AB_CD_0F_0F_E5};
    vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 64'hA5_00_00_00_00_00_00_A5};
    vecs[2] = '{16'h0001, 16'h8000, 16'h7F00, 64'hA5_00_01_80_00_7F_00_5B};
    vecs[3] = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 64'hA5_DE_AD_BE_EF_CA_FE_B3};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst tx_en", 64'(tx_en), 64'd0);
    check("rst tx_data", 64'(tx_data), 64'h00);
    check("rst pkt_done", 64'(pkt_done), 64'd0);
    check("rst overrun", 64'(overrun), 64'd0);
    check("rst timeout_err", 64'(timeout_err), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post-rst sample_ready", 64'(sample_ready), 64'd1);

    // Table of packets, issued back-to-back (each offered the cycle after
    // the previous pkt_done)
    for (int i = 0; i < 4; i++) begin
      run_packet(vecs[i], $sformatf("vec%0d", i), 1'b0);
    end

    // Overrun during byte 3: packet must still carry the captured sample
    run_packet(vecs[3], "ovr", 1'b1);
    @(negedge clk) clear_flags = 1'b1;
    @(negedge clk) clear_flags = 1'b0;
    check("ovr cleared", 64'(overrun), 64'd0);

    // New overrun in the same cycle as clear: set wins
    @(negedge clk);
    x_data = vecs[0].x; y_data = vecs[0].y; z_data = vecs[0].z;
    sample_valid = 1'b1;
    @(negedge clk);
    clear_flags = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    clear_flags = 1'b0;
    check("ovr set beats clear", 64'(overrun), 64'd1);
    seen = 1'b0;
    for (int cyc = 0; cyc < 1000 && !seen; cyc++) begin
      @(negedge clk);
      if (pkt_done) seen = 1'b1;
    end
    check("ovr2 pkt_done seen", 64'(seen), 64'd1);
    @(negedge clk) clear_flags = 1'b1;
    @(negedge clk) clear_flags = 1'b0;

    // Transmitter never raises busy: abort after BUSY_TIMEOUT REQ cycles
    stall = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    x_data = vecs[2].x; y_data = vecs[2].y; z_data = vecs[2].z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    for (int cyc = 0; cyc < 10 && !tx_en; cyc++) @(negedge clk);
    n = 0;
    for (int cyc = 0; cyc < 100 && tx_en; cyc++) begin
      n++;
      @(negedge clk);
    end
    check("to tx_en high cycles", 64'(n), 64'd16);
    check("to timeout_err", 64'(timeout_err), 64'd1);
    check("to tx_en low", 64'(tx_en), 64'd0);
    check("to sample_ready", 64'(sample_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("to no pkt_done", 64'(done_cnt - d0), 64'd0);
    stall = 1'b0;
    clear_flags = 1'b1;
    @(negedge clk) clear_flags = 1'b0;
    check("to cleared", 64'(timeout_err), 64'd0);

    // Reset while waiting on byte 4
    cap.delete();
    @(negedge clk);
    x_data = vecs[3].x; y_data = vecs[3].y; z_data = vecs[3].z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 1000 && !seen; cyc++) begin
      @(negedge clk);
      if (cap.size() == 5 && tx_busy && !tx_en) seen = 1'b1;
    end
    check("mrst reached byte4 wait", 64'(seen), 64'd1);
    check("mrst tx_data before", 64'(tx_data), 64'hEF);
    #2 reset = 1'b0;
    #1;
    check("mrst tx_en", 64'(tx_en), 64'd0);
    check("mrst tx_data", 64'(tx_data), 64'h00);
    check("mrst pkt_done", 64'(pkt_done), 64'd0);
    for (int cyc = 0; cyc < 100 && tx_busy; cyc++) @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst sample_ready", 64'(sample_ready), 64'd1);
    run_packet(vecs[0], "after_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
